// File: rtl/fizzbuzz_pkg.sv
// -----------------------------------------------------------------------------
// fizzbuzz_pkg
// Shared types and helpers for the fizzbuzz stream monitor.
//   fb_state_e  : monitor FSM state (HUNT, LOCKED)
//   fb_flags_t  : {fizz, buzz, fizzbuzz} flag triple
//   fb_expect() : expected flag triple for a beat index and the two divisors
// -----------------------------------------------------------------------------
package fizzbuzz_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } fb_state_e;

    typedef struct packed {
        logic fizz;
        logic buzz;
        logic fizzbuzz;
    } fb_flags_t;

    function automatic fb_flags_t fb_expect(input int unsigned idx,
                                            input int unsigned fizz_div,
                                            input int unsigned buzz_div);
        fb_flags_t f;
        f.fizz     = ((idx % fizz_div) == 0);
        f.buzz     = ((idx % buzz_div) == 0);
        f.fizzbuzz = f.fizz & f.buzz;
        return f;
    endfunction

endpackage

// File: rtl/fizzbuzz_expect.sv
// -----------------------------------------------------------------------------
// fizzbuzz_expect
// Beat index wrap counter (0..MAX_COUNT-1) and the expected flags for the
// index it currently holds.
// Ports:
//   clk, resetn : clock, synchronous active-low reset (index -> 0)
//   ld0_i       : load index 0 (highest priority after reset)
//   ld1_i       : load index 1
//   adv_i       : advance index with wrap MAX_COUNT-1 -> 0
//   idx_o       : current index
//   exp_o       : expected flags for idx_o
// -----------------------------------------------------------------------------
module fizzbuzz_expect
    import fizzbuzz_pkg::*;
#(
    parameter int MAX_COUNT = 6,
    parameter int FIZZ      = 2,
    parameter int BUZZ      = 3,
    localparam int IW       = $clog2(MAX_COUNT)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          ld0_i,
    input  logic          ld1_i,
    input  logic          adv_i,
    output logic [IW-1:0] idx_o,
    output fb_flags_t     exp_o
);

    logic [IW-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (ld0_i)
            idx_d = '0;
        else if (ld1_i)
            idx_d = IW'(1);
        else if (adv_i)
            idx_d = (idx_q == IW'(MAX_COUNT - 1)) ? '0 : idx_q + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            idx_q <= '0;
        else
            idx_q <= idx_d;
    end

    assign idx_o = idx_q;
    assign exp_o = fb_expect(32'(idx_q), FIZZ, BUZZ);

endmodule

// File: rtl/fizzbuzz_monitor.sv
// -----------------------------------------------------------------------------
// fizzbuzz_monitor
// Receiving-side checker for the fizz/buzz/fizzbuzz flag stream. Hunts for the
// all-ones beat (index 0), locks onto the generator phase, predicts each beat
// and flags mismatches. LOSS_THRESH consecutive mismatches drop lock.
// Optional feature macro: FIZZBUZZ_MONITOR_ERRCNT_EN
//   defined   : err_count is a saturating mismatch counter
//   undefined : err_count register omitted, output tied to 0
// Ports:
//   clk, resetn        : clock, synchronous active-low reset
//   in_valid           : beat qualifier
//   in_fizz/buzz/fizzbuzz : received flags
//   clr                : resync request (-> HUNT, err_count cleared, beat dropped)
//   locked             : high while LOCKED
//   err_pulse          : one-cycle mismatch indication
//   err_count          : saturating mismatch count
//   beat_idx           : index expected for the next beat (valid while locked)
// -----------------------------------------------------------------------------
module fizzbuzz_monitor
    import fizzbuzz_pkg::*;
#(
    parameter int MAX_COUNT   = 6,
    parameter int FIZZ        = 2,
    parameter int BUZZ        = 3,
    parameter int LOSS_THRESH = 3,
    parameter int ERR_W       = 8,
    localparam int IW         = $clog2(MAX_COUNT)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic             in_fizz,
    input  logic             in_buzz,
    input  logic             in_fizzbuzz,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [IW-1:0]    beat_idx
);

    localparam int MW = $clog2(LOSS_THRESH + 1);

    fb_state_e     state_q;
    logic          locked_q;
    logic          err_pulse_q;
    logic [MW-1:0] miss_q, miss_d;

    fb_flags_t     rx_w, exp_w;
    logic          beat_w, sync_w, mism_w, lost_w;
    logic          ld0_w, ld1_w, adv_w;

    // clr wins over a coincident beat, so the beat is simply not "accepted".
    always_comb begin
        rx_w.fizz     = in_fizz;
        rx_w.buzz     = in_buzz;
        rx_w.fizzbuzz = in_fizzbuzz;
        beat_w = in_valid & ~clr;
        sync_w = beat_w & (state_q == HUNT) & (&rx_w);
        mism_w = beat_w & (state_q == LOCKED) & (rx_w != exp_w);
        miss_d = miss_q + MW'(1);
        lost_w = mism_w & (miss_d == MW'(LOSS_THRESH));
        ld0_w  = clr | lost_w;
        ld1_w  = sync_w;
        // Index advances on mismatches too, keeping phase across one bad beat.
        adv_w  = beat_w & (state_q == LOCKED) & ~lost_w;
    end

    fizzbuzz_expect #(
        .MAX_COUNT (MAX_COUNT),
        .FIZZ      (FIZZ),
        .BUZZ      (BUZZ)
    ) u_expect (
        .clk    (clk),
        .resetn (resetn),
        .ld0_i  (ld0_w),
        .ld1_i  (ld1_w),
        .adv_i  (adv_w),
        .idx_o  (beat_idx),
        .exp_o  (exp_w)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= HUNT;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            miss_q      <= '0;
        end else if (clr) begin
            state_q     <= HUNT;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            miss_q      <= '0;
        end else begin
            err_pulse_q <= mism_w;
            case (state_q)
                HUNT: begin
                    if (sync_w) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                        miss_q   <= '0;
                    end
                end
                LOCKED: begin
                    if (beat_w) begin
                        if (lost_w) begin
                            state_q  <= HUNT;
                            locked_q <= 1'b0;
                            miss_q   <= '0;
                        end else if (mism_w) begin
                            miss_q <= miss_d;
                        end else begin
                            miss_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q  <= HUNT;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;

`ifdef FIZZBUZZ_MONITOR_ERRCNT_EN
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    // Saturate at all-ones rather than wrapping.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr)
            err_cnt_d = '0;
        else if (mism_w && (err_cnt_q != {ERR_W{1'b1}}))
            err_cnt_d = err_cnt_q + ERR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            err_cnt_q <= '0;
        else
            err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_fizzbuzz_monitor.sv
// -----------------------------------------------------------------------------
// tb_fizzbuzz_monitor
// Directed checks of the fizzbuzz monitor: reset, clean stream, late start,
// single corruption, loss/relock, clr vs beat, mid-run reset, saturation.
// Two instances share stimulus: ERR_W=8 and ERR_W=2 (saturation).
// -----------------------------------------------------------------------------
module tb_fizzbuzz_monitor;

    logic       clk = 1'b0;
    logic       resetn, in_valid, in_fizz, in_buzz, in_fizzbuzz, clr;
    logic       locked, err_pulse, locked2, err_pulse2;
    logic [7:0] err_count;
    logic [1:0] err_count2;
    logic [2:0] beat_idx, beat_idx2;

    int nvec = 0;
    int nmis = 0;

    // Expected (fizz,buzz,fizzbuzz) for index 0..5 with FIZZ=2, BUZZ=3.
    logic [2:0] exp_tab [6] = '{3'b111, 3'b000, 3'b100, 3'b010, 3'b100, 3'b000};

    always #5 clk = ~clk;

    fizzbuzz_monitor #(.MAX_COUNT(6), .FIZZ(2), .BUZZ(3), .LOSS_THRESH(3), .ERR_W(8)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_fizz(in_fizz),
        .in_buzz(in_buzz), .in_fizzbuzz(in_fizzbuzz), .clr(clr),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .beat_idx(beat_idx)
    );

    fizzbuzz_monitor #(.MAX_COUNT(6), .FIZZ(2), .BUZZ(3), .LOSS_THRESH(3), .ERR_W(2)) dut2 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_fizz(in_fizz),
        .in_buzz(in_buzz), .in_fizzbuzz(in_fizzbuzz), .clr(clr),
        .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2), .beat_idx(beat_idx2)
    );

    // Expected err_count for n mismatches, depending on whether the counter is built.
    function automatic int ec(input int n);
`ifdef FIZZBUZZ_MONITOR_ERRCNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: present inputs, take the edge, settle 1 time unit past it.
    task automatic drive(input logic v, input logic [2:0] f, input logic c);
        in_valid = v;
        {in_fizz, in_buzz, in_fizzbuzz} = f;
        clr = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        int idx;
        resetn = 1'b0; in_valid = 1'b0; clr = 1'b0;
        in_fizz = 1'b0; in_buzz = 1'b0; in_fizzbuzz = 1'b0;
        drive(1'b0, 3'b000, 1'b0);
        drive(1'b0, 3'b000, 1'b0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err_pulse", 32'(err_pulse), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_beat_idx", 32'(beat_idx), 0);
        resetn = 1'b1;

        // Clean stream: two periods starting at index 0.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 6; k++) begin
                drive(1'b1, exp_tab[k], 1'b0);
                chk("clean_locked", 32'(locked), 1);
                chk("clean_idx", 32'(beat_idx), 32'((k + 1) % 6));
                chk("clean_err_pulse", 32'(err_pulse), 0);
            end
        end
        chk("clean_err_count", 32'(err_count), 0);

        // Back to HUNT, then start mid-period at index 3.
        drive(1'b0, 3'b000, 1'b1);
        chk("clr_locked", 32'(locked), 0);
        for (int k = 3; k < 6; k++) begin
            drive(1'b1, exp_tab[k], 1'b0);
            chk("late_locked", 32'(locked), 0);
            chk("late_err_pulse", 32'(err_pulse), 0);
        end
        drive(1'b1, 3'b111, 1'b0);
        chk("late_lock", 32'(locked), 1);
        chk("late_idx", 32'(beat_idx), 1);
        drive(1'b1, 3'b000, 1'b0);
        chk("late_idx2", 32'(beat_idx), 2);

        // Single corruption at index 2.
        drive(1'b1, 3'b000, 1'b0);
        chk("corr_err_pulse", 32'(err_pulse), 1);
        chk("corr_err_count", 32'(err_count), 32'(ec(1)));
        chk("corr_idx", 32'(beat_idx), 3);
        chk("corr_locked", 32'(locked), 1);
        drive(1'b1, 3'b010, 1'b0);
        chk("corr_pulse_off", 32'(err_pulse), 0);
        chk("corr_still_locked", 32'(locked), 1);

        // Idle cycle changes nothing.
        drive(1'b0, 3'b111, 1'b0);
        chk("idle_idx", 32'(beat_idx), 4);
        chk("idle_locked", 32'(locked), 1);

        // Loss of lock: clear, relock, then 000 where 100,010,100 expected.
        drive(1'b0, 3'b000, 1'b1);
        chk("clr_err_count", 32'(err_count), 0);
        drive(1'b1, 3'b111, 1'b0);
        drive(1'b1, 3'b000, 1'b0);
        for (int m = 1; m <= 3; m++) begin
            drive(1'b1, 3'b000, 1'b0);
            chk("loss_err_pulse", 32'(err_pulse), 1);
            chk("loss_err_count", 32'(err_count), 32'(ec(m)));
            chk("loss_locked", 32'(locked), (m < 3) ? 1 : 0);
        end
        chk("loss_idx", 32'(beat_idx), 0);
        drive(1'b1, 3'b000, 1'b0);
        chk("hunt_no_pulse", 32'(err_pulse), 0);
        chk("hunt_locked", 32'(locked), 0);
        drive(1'b1, 3'b111, 1'b0);
        chk("relock", 32'(locked), 1);
        chk("relock_idx", 32'(beat_idx), 1);

        // clr with a mismatching beat in the same cycle.
        drive(1'b1, 3'b111, 1'b1);
        chk("clrv_err_pulse", 32'(err_pulse), 0);
        chk("clrv_err_count", 32'(err_count), 0);
        chk("clrv_locked", 32'(locked), 0);

        // Reset mid-period while an err_pulse is high.
        drive(1'b1, 3'b111, 1'b0);
        drive(1'b1, 3'b100, 1'b0);
        chk("pre_rst_pulse", 32'(err_pulse), 1);
        resetn = 1'b0;
        drive(1'b1, 3'b000, 1'b0);
        chk("mrst_locked", 32'(locked), 0);
        chk("mrst_err_pulse", 32'(err_pulse), 0);
        chk("mrst_err_count", 32'(err_count), 0);
        chk("mrst_idx", 32'(beat_idx), 0);
        chk("mrst_err_count2", 32'(err_count2), 0);
        resetn = 1'b1;

        // Saturation: seven isolated mismatches, each followed by a good beat.
        drive(1'b1, 3'b111, 1'b0);
        idx = 1;
        for (int n = 1; n <= 7; n++) begin
            drive(1'b1, exp_tab[idx] ^ 3'b001, 1'b0);
            idx = (idx + 1) % 6;
            chk("sat_err_pulse", 32'(err_pulse2), 1);
            chk("sat_err_count2", 32'(err_count2), 32'(ec((n < 3) ? n : 3)));
            chk("sat_err_count8", 32'(err_count), 32'(ec(n)));
            drive(1'b1, exp_tab[idx], 1'b0);
            idx = (idx + 1) % 6;
            chk("sat_pulse_off", 32'(err_pulse2), 0);
            chk("sat_locked", 32'(locked2), 1);
        end
        chk("sat_idx", 32'(beat_idx2), 32'(idx));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/fizzbuzz_monitor.md
# fizzbuzz_monitor

Receiving-side checker for the fizz/buzz/fizzbuzz flag stream produced by the team's fizzbuzz generator. It hunts for the sequence start, locks onto the generator's phase, and predicts each beat. It reports mismatches, keeps an error count and drops lock after repeated errors. It sits on the generator's output, in the bench or in-system as a self-check.

## Interface
- MAX_COUNT, 6: sequence period in beats; index runs 0..MAX_COUNT-1 then wraps; must be ≥2
- FIZZ, 2: fizz divisor, ≥1
- BUZZ, 3: buzz divisor, ≥1
- LOSS_THRESH, 3: consecutive mismatches that drop lock, ≥1
- ERR_W, 8: err_count width
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- in_valid  in  1  beat qualifier; flags sampled only when high
- in_fizz  in  1  received fizz flag
- in_buzz  in  1  received buzz flag
- in_fizzbuzz  in  1  received fizzbuzz flag
- clr  in  1  synchronous resync request; forces HUNT and clears err_count
- locked  out  1  high while in LOCKED
- err_pulse  out  1  one-cycle mismatch indication
- err_count  out  ERR_W  saturating mismatch count
- beat_idx  out  $clog2(MAX_COUNT)  index expected for the next beat; meaningful only while locked

## Operation
- Expected flags at index i:
  - fizz = (i % FIZZ == 0)
  - buzz = (i % BUZZ == 0)
  - fizzbuzz = fizz & buzz
- A beat matches when all three received flags equal the expected flags.
- States: HUNT, LOCKED.
- HUNT:
  - Ignores beats until an accepted beat has fizz=buzz=fizzbuzz=1.
  - On that beat: go to LOCKED, set beat_idx=1, clear the miss counter.
  - No errors are flagged in HUNT.
- LOCKED, on each accepted beat: compare the beat against the expectation for beat_idx, then advance beat_idx, wrapping MAX_COUNT-1 → 0.
  - On a match: clear the miss counter.
  - On a mismatch: assert err_pulse, increment err_count (saturates at 2^ERR_W-1, never wraps), increment the miss counter.
  - When the miss counter reaches LOSS_THRESH: go to HUNT; beat_idx is reset to 0.
- beat_idx advances on mismatches too, so a single corrupted beat does not shift phase.
- clr in the same cycle as in_valid: clr wins. The beat is discarded, the state goes to HUNT, err_count is cleared, and there is no err_pulse.
- Cycles with in_valid=0 change nothing.

## Timing
- All outputs are registered and update on the clk edge that accepts the beat.
- err_pulse is high exactly one cycle after the offending beat's edge.
- locked rises one cycle after the resyncing beat's edge.
- locked falls one cycle after the LOSS_THRESH-th consecutive mismatch's edge.
- Back-to-back beats are supported every cycle; the block has no backpressure.
- Reset, including mid-operation, applies at the next edge:
  - locked=0, err_pulse=0, err_count=0, beat_idx=0
  - state HUNT, miss counter 0

## Configuration
- FIZZBUZZ_MONITOR_ERRCNT_EN defined: err_count counts as specified.
- Undefined: the err_count register is omitted and the output is tied to 0. err_pulse, lock and loss behaviour are unchanged.

## Structure
- fizzbuzz_pkg holds:
  - the state enum (HUNT, LOCKED)
  - the expected-flags struct {fizz, buzz, fizzbuzz}
  - a function computing the expected flags from an index and the divisors
- One sub-module, fizzbuzz_expect: the beat_idx wrap counter with advance/load-zero/load-one controls, producing the expected-flag struct.
- The monitor top holds the FSM, the miss counter and err_count.

## Test plan
All scenarios use MAX_COUNT=6, FIZZ=2, BUZZ=3, LOSS_THRESH=3. The expected (fizz,buzz,fizzbuzz) sequence for index 0..5 is 111, 000, 100, 010, 100, 000.
- Clean stream: send two full periods back-to-back starting at index 0 → locked=1 one cycle after beat 0; err_pulse never asserts; err_count=0; beat_idx cycles 1..5,0.
- Late start: begin the stream at index 3 → locked stays 0 for beats 3,4,5; locks on the following 111 beat; no errors.
- Single corruption: while locked, send index 2 as 000 → one err_pulse; err_count=1; beat_idx still advances to 3; remains locked.
- Loss of lock: while locked, send three consecutive 000 beats where 100, 010, 100 are expected → err_count=3; locked falls after the third; next 111 beat relocks.
- Simultaneous clr and in_valid carrying a mismatch → no err_pulse; err_count=0; state HUNT. Reset asserted mid-period → all outputs 0 next cycle.
- Saturation: ERR_W=2 with seven isolated mismatches → err_count holds at 3. With FIZZBUZZ_MONITOR_ERRCNT_EN undefined, err_count stays 0 while err_pulse still fires.
